// File: rtl/fetch_stage.sv
// IF stage and IF/ID register: PC, single-outstanding imem req/ready fetch, one-entry skid for stalled returns.
// Optional IF_DELAY_SLOT_EN: a branch redirect keeps the current IF/ID word instead of flushing it.
module fetch_stage #(
   parameter int            AW       = 32,
   parameter logic [AW-1:0] RESET_PC = '0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          stall,
   input  logic          branch_taken,
   input  logic [AW-1:0] branch_target,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic          imem_ready,
   input  logic [31:0]   imem_rdata,
   output logic [31:0]   instr_d,
   output logic [AW-1:0] pcplus4_d,
   output logic          valid_d,
   output logic [5:0]    op_d,
   output logic [5:0]    funct_d,
   output logic [1:0]    dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] pc, pc_nxt, pc_inc;
   logic [31:0]   instr_nxt;
   logic [AW-1:0] pcp4_nxt;
   logic          valid_nxt;
   logic [31:0]   skid_instr, skid_instr_nxt;
   logic [AW-1:0] skid_pcp4, skid_pcp4_nxt;

   // Handshake: imem_req is high only in S_REQ with imem_addr = pc held steady; a cycle
   // with imem_req & imem_ready transfers imem_rdata and retires the request.
   assign imem_req  = (state == S_REQ);
   assign imem_addr = pc;
   assign op_d      = instr_d[31:26];
   assign funct_d   = instr_d[5:0];
   assign dbg_state = state;
   assign pc_inc    = pc + AW'(4);

   always_comb begin
      state_nxt      = state;
      pc_nxt         = pc;
      instr_nxt      = instr_d;
      pcp4_nxt       = pcplus4_d;
      valid_nxt      = valid_d;
      skid_instr_nxt = skid_instr;
      skid_pcp4_nxt  = skid_pcp4;
      if (branch_taken) begin
         pc_nxt    = branch_target;
         state_nxt = S_REQ;
`ifdef IF_DELAY_SLOT_EN
         instr_nxt = instr_d;
         valid_nxt = valid_d;
`else
         instr_nxt = 32'h0;
         valid_nxt = 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               state_nxt = S_REQ;
               if (!stall) begin
                  instr_nxt = 32'h0;
                  valid_nxt = 1'b0;
               end
            end
            S_REQ: begin
               if (imem_ready) begin
                  pc_nxt = pc_inc;
                  // A word returning under stall is parked so the request is never lost.
                  if (stall) begin
                     skid_instr_nxt = imem_rdata;
                     skid_pcp4_nxt  = pc_inc;
                     state_nxt      = S_HOLD;
                  end else begin
                     instr_nxt = imem_rdata;
                     pcp4_nxt  = pc_inc;
                     valid_nxt = 1'b1;
                  end
               end else if (!stall) begin
                  instr_nxt = 32'h0;
                  valid_nxt = 1'b0;
               end
            end
            S_HOLD: begin
               if (!stall) begin
                  instr_nxt = skid_instr;
                  pcp4_nxt  = skid_pcp4;
                  valid_nxt = 1'b1;
                  state_nxt = S_REQ;
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         pc         <= RESET_PC;
         instr_d    <= 32'h0;
         pcplus4_d  <= '0;
         valid_d    <= 1'b0;
         skid_instr <= 32'h0;
         skid_pcp4  <= '0;
      end else begin
         state      <= state_nxt;
         pc         <= pc_nxt;
         instr_d    <= instr_nxt;
         pcplus4_d  <= pcp4_nxt;
         valid_d    <= valid_nxt;
         skid_instr <= skid_instr_nxt;
         skid_pcp4  <= skid_pcp4_nxt;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random traffic, checked against a
// transaction-level model (fetch started flag, parked-word queue, IF/ID contents).
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n, stall, branch_taken, imem_ready;
   logic [31:0] branch_target, imem_rdata;
   logic        imem_req, valid_d, imem_req1, valid_d1;
   logic [31:0] imem_addr, instr_d, pcplus4_d, imem_addr1, instr_d1, pcplus4_d1;
   logic [5:0]  op_d, funct_d, op_d1, funct_d1;
   logic [1:0]  dbg_state, dbg_state1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fetch_stage #(.AW(32), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
      .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr_d(instr_d),
      .pcplus4_d(pcplus4_d), .valid_d(valid_d), .op_d(op_d), .funct_d(funct_d),
      .dbg_state(dbg_state));

   fetch_stage #(.AW(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
      .branch_target(branch_target), .imem_req(imem_req1), .imem_addr(imem_addr1),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr_d(instr_d1),
      .pcplus4_d(pcplus4_d1), .valid_d(valid_d1), .op_d(op_d1), .funct_d(funct_d1),
      .dbg_state(dbg_state1));

   // Reference model: fetch engine seen as "has it started", a queue of parked words,
   // and the IF/ID contents.
   logic [31:0] m_pc, m_instr, m_pcp4;
   logic        m_valid, m_started;
   logic [31:0] exp_q[$];
   logic [31:0] exp_pc_q[$];

   task automatic model_edge();
      if (!rst_n) begin
         m_pc = 32'h0; m_started = 1'b0; exp_q.delete(); exp_pc_q.delete();
         m_instr = 32'h0; m_pcp4 = 32'h0; m_valid = 1'b0;
      end else if (branch_taken) begin
         m_pc = branch_target; m_started = 1'b1; exp_q.delete(); exp_pc_q.delete();
`ifndef IF_DELAY_SLOT_EN
         m_instr = 32'h0; m_valid = 1'b0;
`endif
      end else if (!m_started) begin
         m_started = 1'b1;
         if (!stall) begin m_instr = 32'h0; m_valid = 1'b0; end
      end else if (exp_q.size() > 0) begin
         if (!stall) begin
            m_instr = exp_q.pop_front(); m_pcp4 = exp_pc_q.pop_front(); m_valid = 1'b1;
         end
      end else if (imem_ready) begin
         if (stall) begin
            exp_q.push_back(imem_rdata); exp_pc_q.push_back(m_pc + 32'd4);
         end else begin
            m_instr = imem_rdata; m_pcp4 = m_pc + 32'd4; m_valid = 1'b1;
         end
         m_pc = m_pc + 32'd4;
      end else if (!stall) begin
         m_instr = 32'h0; m_valid = 1'b0;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      logic [31:0] e_instr;
      e_instr = m_instr;
      check({tag, ".req"},   {31'h0, imem_req}, {31'h0, m_started && (exp_q.size() == 0)});
      check({tag, ".addr"},  imem_addr, m_pc);
      check({tag, ".instr"}, instr_d, m_instr);
      check({tag, ".pcp4"},  pcplus4_d, m_pcp4);
      check({tag, ".valid"}, {31'h0, valid_d}, {31'h0, m_valid});
      check({tag, ".op"},    {26'h0, op_d}, {26'h0, e_instr[31:26]});
      check({tag, ".funct"}, {26'h0, funct_d}, {26'h0, e_instr[5:0]});
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_model(tag);
   endtask

   task automatic idle_inputs();
      stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
      imem_ready = 1'b0; imem_rdata = 32'h0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0; tick("rst");
      rst_n = 1'b1; tick("idle");
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      m_pc = 32'h0; m_started = 1'b0; m_instr = 32'h0; m_pcp4 = 32'h0; m_valid = 1'b0;

      // 1: streaming fetch, rdata = addr | 1; the wrap instance starts at FFFF_FFFC
      do_reset();
      check("t1.req0", {31'h0, imem_req}, 32'h1);
      check("t1.addr0", imem_addr, 32'h0);
      check("t5.addr_wrap0", imem_addr1, 32'hFFFF_FFFC);
      imem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         imem_rdata = m_pc | 32'h1;
         tick("t1");
         if (i == 0) begin
            check("t5.addr_wrap1", imem_addr1, 32'h0);
            check("t5.pcp4_wrap", pcplus4_d1, 32'h0);
         end
         check("t1.instr", instr_d, 32'(4 * i + 1));
         check("t1.addr", imem_addr, 32'(4 * i + 4));
         check("t1.valid", {31'h0, valid_d}, 32'h1);
      end

      // 2: ready held low three cycles at address 8
      do_reset();
      imem_ready = 1'b1;
      imem_rdata = 32'h1; tick("t2");
      imem_rdata = 32'h5; tick("t2");
      imem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick("t2w");
         check("t2.addr_hold", imem_addr, 32'h8);
         check("t2.valid_low", {31'h0, valid_d}, 32'h0);
      end
      imem_ready = 1'b1; imem_rdata = 32'h9; tick("t2");
      check("t2.instr9", instr_d, 32'h9);

      // 3: stall coincident with ready at address 4
      do_reset();
      imem_ready = 1'b1; imem_rdata = 32'h1; tick("t3");
      stall = 1'b1; imem_rdata = 32'h5; tick("t3s");
      check("t3.instr_hold", instr_d, 32'h1);
      check("t3.req_off", {31'h0, imem_req}, 32'h0);
      stall = 1'b0; imem_ready = 1'b0; tick("t3r");
      check("t3.instr5", instr_d, 32'h5);
      check("t3.addr8", imem_addr, 32'h8);

      // 4: branch with a same-cycle ready drops the returning word
      do_reset();
      imem_ready = 1'b1; imem_rdata = 32'h1; tick("t4");
      branch_taken = 1'b1; branch_target = 32'h40; imem_rdata = 32'h5; tick("t4b");
`ifdef IF_DELAY_SLOT_EN
      check("t4.slot_instr", instr_d, 32'h1);
      check("t4.slot_valid", {31'h0, valid_d}, 32'h1);
`else
      check("t4.flush_instr", instr_d, 32'h0);
      check("t4.flush_valid", {31'h0, valid_d}, 32'h0);
`endif
      check("t4.addr40", imem_addr, 32'h40);
      branch_taken = 1'b0;

      // 6: reset during an outstanding request
      do_reset();
      tick("t6w"); tick("t6w");
      rst_n = 1'b0; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF; tick("t6r");
      check("t6.req", {31'h0, imem_req}, 32'h0);
      check("t6.addr", imem_addr, 32'h0);
      check("t6.valid", {31'h0, valid_d}, 32'h0);
      check("t6.instr", instr_d, 32'h0);
      rst_n = 1'b1; tick("t6i");
      check("t6.wrap_addr", imem_addr1, 32'hFFFF_FFFC);

      // Random traffic against the model
      for (int n = 0; n < 2000; n++) begin
         rst_n         = ($urandom_range(0, 99) != 0);
         stall         = ($urandom_range(0, 3) == 0);
         branch_taken  = ($urandom_range(0, 11) == 0);
         branch_target = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom();
         imem_ready    = $urandom_range(0, 1) == 1;
         imem_rdata    = $urandom();
         tick("rnd");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
